// File: rtl/irq_stim_scheduler.sv
// irq_stim_scheduler: buffers timed interrupt commands in a small FIFO and
// plays them out one at a time on the core's irq lines. Each command waits
// a programmed number of idle cycles, then raises its line for a programmed
// width, or leaves it raised until clear_all when the width is zero.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the registered FIFO
// count, never on cmd_valid. The host holds a command stable while
// cmd_valid is high and cmd_ready is low.
module irq_stim_scheduler #(
  parameter int DEPTH   = 4,
  parameter int DELAY_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_irq_id,
  input  logic [DELAY_W-1:0]         cmd_delay,
  input  logic [DELAY_W-1:0]         cmd_hold,
  input  logic                       clear_all,
  output logic                       irq_software,
  output logic                       irq_timer,
  output logic                       irq_external,
  output logic [14:0]                irq_fast,
  output logic                       irq_nm,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_bad_id,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int NUM_IRQ = 19;

  // Bit positions in irq_q: 0 software, 1 timer, 2 external,
  // 3..17 fast[0..14], 18 nm. The command id is the bit index.
  localparam logic [4:0] MAX_ID = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]         id;
    logic [DELAY_W-1:0] delay;
    logic [DELAY_W-1:0] hold;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] hold_q, hold_d;
  logic [4:0]         id_q, id_d;
  logic               err_q, err_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;

  logic               push;
  logic               pop;
  logic               set_en;
  logic               clr_en;
  entry_t             head;

  assign cmd_ready = (count_q < CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // FIFO storage, pointers and occupancy; pointers wrap as DEPTH is a power of 2
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{id: cmd_irq_id, delay: cmd_delay, hold: cmd_hold};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Command sequencer: pop, count down the delay, assert, count down the hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    id_d    = id_q;
    err_d   = err_q;
    pop     = 1'b0;
    set_en  = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head.id > MAX_ID) begin
            // An unknown id is dropped without touching any line.
            err_d = 1'b1;
          end else begin
            id_d    = head.id;
            hold_d  = head.hold;
            cnt_d   = head.delay;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_W'(1);
        end else begin
          set_en = 1'b1;
          if (hold_q != '0) begin
            // The assertion edge itself is the first high cycle.
            cnt_d   = hold_q - DELAY_W'(1);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_W'(1);
        end else begin
          clr_en  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // irq line bits: clear_all wipes all, then the sequencer's set/clear applies
  always_comb begin
    irq_d = clear_all ? '0 : irq_q;
    if (set_en) irq_d[id_q] = 1'b1;
    if (clr_en) irq_d[id_q] = 1'b0;
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      irq_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      id_q     <= id_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_software = irq_q[0];
  assign irq_timer    = irq_q[1];
  assign irq_external = irq_q[2];
  assign irq_fast     = irq_q[17:3];
  assign irq_nm       = irq_q[18];
  assign busy         = (state_q != ST_IDLE) || (count_q != '0);
  assign fifo_count   = count_q;
  assign err_bad_id   = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_irq_stim_scheduler.sv
// Directed bench for irq_stim_scheduler. Edge numbers in comments count
// rising clk edges from the edge that accepts the first command of a step.
module tb_irq_stim_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_irq_id;
  logic [15:0] cmd_delay;
  logic [15:0] cmd_hold;
  logic        clear_all;
  logic        irq_software;
  logic        irq_timer;
  logic        irq_external;
  logic [14:0] irq_fast;
  logic        irq_nm;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        err_bad_id;
  logic [1:0]  dbg_state;

  logic [18:0] irq_vec;
  assign irq_vec = {irq_nm, irq_fast, irq_external, irq_timer, irq_software};

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // clock / reset
  always #5 clk = ~clk;

  irq_stim_scheduler #(.DEPTH(4), .DELAY_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_irq_id   (cmd_irq_id),
    .cmd_delay    (cmd_delay),
    .cmd_hold     (cmd_hold),
    .clear_all    (clear_all),
    .irq_software (irq_software),
    .irq_timer    (irq_timer),
    .irq_external (irq_external),
    .irq_fast     (irq_fast),
    .irq_nm       (irq_nm),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .err_bad_id   (err_bad_id),
    .dbg_state    (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic drive_cmd(input logic [4:0] id, input logic [15:0] dly, input logic [15:0] hld);
    cmd_valid  = 1'b1;
    cmd_irq_id = id;
    cmd_delay  = dly;
    cmd_hold   = hld;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until any irq line is high (bounded), then check which and when.
  task automatic wait_vec(input string tag, input logic [18:0] exp_vec, input int exp_edge, input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (irq_vec == '0 && n < limit);
    chk({tag, "_seen"}, 32'(irq_vec != '0), 32'd1);
    chk({tag, "_vec"}, 32'(irq_vec), 32'(exp_vec));
    chk({tag, "_edge"}, edge_n, exp_edge);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_irq"}, 32'(irq_vec), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err_bad_id), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_irq_id = '0;
    cmd_delay  = '0;
    cmd_hold   = '0;
    clear_all  = 1'b0;
    repeat (3) tick();
    chk_reset_state("rst_init");
    chk("rst_init_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // 1: reset in the middle of a timer pulse (pop e1, high from e2)
    edge_n = -1;
    drive_cmd(5'd1, 16'd0, 16'd10);
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("t1_timer_high", 32'(irq_timer), 32'd1);
    chk("t1_in_hold", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_state("t1_rst");
    reset = 1'b0;
    tick();
    chk("t1_after_irq", 32'(irq_vec), 32'd0);
    chk("t1_after_busy", 32'(busy), 32'd0);

    // 2: single pulse: pop e1, timer high e7..e9, idle from e10
    edge_n = -1;
    drive_cmd(5'd1, 16'd5, 16'd3);
    tick();
    cmd_valid = 1'b0;
    chk("t2_count_e0", 32'(fifo_count), 32'd1);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("t2_timer_e%0d", e), 32'(irq_vec), (e >= 7 && e <= 9) ? 32'h2 : 32'h0);
      if (e == 1) chk("t2_count_e1", 32'(fifo_count), 32'd0);
    end
    chk("t2_busy_end", 32'(busy), 32'd0);

    // 3: preload keeps the sequencer busy (external at e22) while 4 fill the FIFO
    edge_n = -1;
    drive_cmd(5'd2, 16'd20, 16'd1);
    tick();
    drive_cmd(5'd3, 16'd100, 16'd1); tick();
    drive_cmd(5'd4, 16'd100, 16'd1); tick();
    drive_cmd(5'd5, 16'd100, 16'd1); tick();
    drive_cmd(5'd6, 16'd100, 16'd1); tick();
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_ready_full", 32'(cmd_ready), 32'd0);
    drive_cmd(5'd7, 16'd100, 16'd1);
    wait_vec("t3_ext", 19'h4, 22, 40);
    chk("t3_count_e22", 32'(fifo_count), 32'd4);
    tick();
    chk("t3_ready_e23", 32'(cmd_ready), 32'd0);
    tick();
    chk("t3_count_e24", 32'(fifo_count), 32'd3);
    chk("t3_ready_e24", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t3_count_e25", 32'(fifo_count), 32'd4);
    wait_vec("t3_id3", 19'h8, 125, 200);
    wait_vec("t3_id4", 19'h10, 228, 200);
    wait_vec("t3_id5", 19'h20, 331, 200);
    wait_vec("t3_id6", 19'h40, 434, 200);
    wait_vec("t3_id7", 19'h80, 537, 200);
    tick();
    chk("t3_end_irq", 32'(irq_vec), 32'd0);
    chk("t3_end_busy", 32'(busy), 32'd0);

    // 4: sticky nm from e2, software pulse e6..e9, then clear_all
    edge_n = -1;
    drive_cmd(5'd18, 16'd0, 16'd0); tick();
    drive_cmd(5'd0, 16'd2, 16'd4); tick();
    cmd_valid = 1'b0;
    for (int e = 2; e <= 11; e++) begin
      tick();
      chk($sformatf("t4_vec_e%0d", e), 32'(irq_vec), (e >= 6 && e <= 9) ? 32'h40001 : 32'h40000);
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    chk("t4_clear_irq", 32'(irq_vec), 32'd0);
    chk("t4_clear_busy", 32'(busy), 32'd0);

    // 5: sticky software, then fast[2] rising on the clear_all edge (e7)
    edge_n = -1;
    drive_cmd(5'd0, 16'd0, 16'd0); tick();
    drive_cmd(5'd5, 16'd3, 16'd2); tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk("t5_sticky_e6", 32'(irq_vec), 32'h1);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    chk("t5_collide_vec", 32'(irq_vec), 32'h20);
    chk("t5_collide_fast", 32'(irq_fast), 32'h4);
    tick();
    chk("t5_e8", 32'(irq_vec), 32'h20);
    tick();
    chk("t5_e9", 32'(irq_vec), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);

    // 6: bad id dropped at e1, external pulse at e3 only
    chk("t6_err_before", 32'(err_bad_id), 32'd0);
    edge_n = -1;
    drive_cmd(5'd25, 16'd0, 16'd0); tick();
    drive_cmd(5'd2, 16'd0, 16'd1); tick();
    cmd_valid = 1'b0;
    chk("t6_err_e1", 32'(err_bad_id), 32'd1);
    chk("t6_vec_e1", 32'(irq_vec), 32'h0);
    tick();
    chk("t6_vec_e2", 32'(irq_vec), 32'h0);
    tick();
    chk("t6_vec_e3", 32'(irq_vec), 32'h4);
    tick();
    chk("t6_vec_e4", 32'(irq_vec), 32'h0);
    chk("t6_err_e4", 32'(err_bad_id), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
